// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants and helpers for the hazard scoreboard: the register-file
// forward select code and the width of one forwarding-select field.
package hazard_scoreboard_pkg;

    localparam int FWD_SEL_RF = 0;

    // One select field must encode 0 (register file) plus stages 1..stages.
    function automatic int sel_width(input int stages);
        return (stages < 1) ? 1 : $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-slot bundle between the decoder (master) and the hazard scoreboard (slave).
interface hazard_scoreboard_if #(
    parameter int NUM_SRC = 2,
    parameter int REG_AW  = 5
);

    // An instruction is consumed on any cycle with dec_valid && dec_ready: it
    // either enters S1 or, when kill is high, is squashed. While dec_valid is
    // high and dec_ready is low the master holds every dec_* field stable.
    logic                      dec_valid;
    logic [NUM_SRC*REG_AW-1:0] dec_rs;
    logic [REG_AW-1:0]         dec_rd;
    logic                      dec_we;
    logic                      dec_is_load;
    logic                      dec_ready;

    modport master (
        output dec_valid, dec_rs, dec_rd, dec_we, dec_is_load,
        input  dec_ready
    );

    modport slave (
        input  dec_valid, dec_rs, dec_rd, dec_we, dec_is_load,
        output dec_ready
    );

endinterface

// File: rtl/hazard_scoreboard_fwd_prio_enc.sv
// Per-source priority encoder: match bit j means stage j+1 holds the producer;
// the youngest (lowest) match wins and maps to the stage it occupies next cycle.
module hazard_scoreboard_fwd_prio_enc
    import hazard_scoreboard_pkg::*;
#(
    parameter int N  = 2,
    parameter int SW = 2
) (
    input  logic [N-1:0]  match_i,
    output logic [SW-1:0] sel_o
);

    always_comb begin
        sel_o = SW'(FWD_SEL_RF);
        for (int j = N - 1; j >= 0; j--) begin
            if (match_i[j]) sel_o = SW'(j + 2);
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Destination-register scoreboard for an N-stage pipeline: registered forward
// selects, load-use interlock and branch kill. Define HAZARD_PERF_EN for perf counters.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int STAGES     = 3,   // must be >= 2
    parameter int NUM_SRC    = 2,
    parameter int REG_AW     = 5,
    parameter int LOAD_STAGE = 3
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  freeze,
    input  logic                                  kill,
    hazard_scoreboard_if.slave                    dec,
    output logic [NUM_SRC*sel_width(STAGES)-1:0]  fwd_sel,
    output logic [STAGES-1:0]                     stg_valid,
    output logic [STAGES-1:0]                     stg_we
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]                           perf_stall_cnt,
    output logic [31:0]                           perf_kill_cnt
`endif
);

    localparam int SW = sel_width(STAGES);

    // Index j holds stage S(j+1); rdy is the first stage whose output forwards.
    logic [STAGES-1:0]     vld_q, vld_d, we_q, we_d;
    logic [REG_AW-1:0]     rd_q  [STAGES];
    logic [REG_AW-1:0]     rd_d  [STAGES];
    logic [SW-1:0]         rdy_q [STAGES];
    logic [SW-1:0]         rdy_d [STAGES];
    logic [NUM_SRC*SW-1:0] fwd_q, fwd_d, fwd_raw;
    logic [STAGES-2:0]     match [NUM_SRC];
    logic                  hazard, take, advance;

    assign advance = ~freeze;

    // S_STAGES is excluded: the register file writes through to the decode read.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            match[i] = '0;
            for (int j = 0; j < STAGES - 1; j++) begin
                match[i][j] = vld_q[j] && we_q[j]
                              && (rd_q[j] == dec.dec_rs[i*REG_AW +: REG_AW])
                              && (dec.dec_rs[i*REG_AW +: REG_AW] != '0);
                if (match[i][j] && (j + 2 < int'(rdy_q[j]))) hazard = 1'b1;
            end
        end
        hazard = hazard && dec.dec_valid;
    end

    assign take          = dec.dec_valid && !kill && !hazard;
    assign dec.dec_ready = advance && !(hazard && !kill);

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_enc
        hazard_scoreboard_fwd_prio_enc #(
            .N  (STAGES - 1),
            .SW (SW)
        ) u_enc (
            .match_i (match[gi]),
            .sel_o   (fwd_raw[gi*SW +: SW])
        );
    end

    always_comb begin
        vld_d = vld_q;
        we_d  = we_q;
        rd_d  = rd_q;
        rdy_d = rdy_q;
        fwd_d = fwd_q;
        if (advance) begin
            for (int j = STAGES - 1; j > 0; j--) begin
                vld_d[j] = vld_q[j-1];
                we_d[j]  = we_q[j-1];
                rd_d[j]  = rd_q[j-1];
                rdy_d[j] = rdy_q[j-1];
            end
            vld_d[0] = take;
            we_d[0]  = take && dec.dec_we;
            rd_d[0]  = take ? dec.dec_rd : '0;
            rdy_d[0] = !take ? '0 : (dec.dec_is_load ? SW'(LOAD_STAGE) : SW'(1));
            fwd_d    = take ? fwd_raw : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q <= '0;
            we_q  <= '0;
            fwd_q <= '0;
            for (int j = 0; j < STAGES; j++) begin
                rd_q[j]  <= '0;
                rdy_q[j] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            we_q  <= we_d;
            fwd_q <= fwd_d;
            rd_q  <= rd_d;
            rdy_q <= rdy_d;
        end
    end

    always_comb begin
        stg_we = '0;
        for (int j = 0; j < STAGES; j++) begin
            stg_we[j] = vld_q[j] && we_q[j] && (rd_q[j] != '0);
        end
    end

    assign stg_valid = vld_q;
    assign fwd_sel   = fwd_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d, kill_cnt_q, kill_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        kill_cnt_d  = kill_cnt_q;
        if (advance && hazard && !kill) stall_cnt_d = stall_cnt_q + 32'd1;
        if (advance && kill)            kill_cnt_d  = kill_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            kill_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            kill_cnt_q  <= kill_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_kill_cnt  = kill_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: a default instance (A) and a STAGES=5/LOAD_STAGE=4
// instance (B) checked every cycle against an in-flight-instruction model.
module tb_hazard_scoreboard;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, freeze, kill;
    logic       drv_dv, drv_we, drv_ld;
    logic [9:0] drv_rs;
    logic [4:0] drv_rd;
    int         phase;

    hazard_scoreboard_if #(.NUM_SRC(2), .REG_AW(5)) if_a ();
    hazard_scoreboard_if #(.NUM_SRC(2), .REG_AW(5)) if_b ();

    assign if_a.dec_valid   = drv_dv && (phase == 0);
    assign if_a.dec_rs      = drv_rs;
    assign if_a.dec_rd      = drv_rd;
    assign if_a.dec_we      = drv_we;
    assign if_a.dec_is_load = drv_ld;
    assign if_b.dec_valid   = drv_dv && (phase == 1);
    assign if_b.dec_rs      = drv_rs;
    assign if_b.dec_rd      = drv_rd;
    assign if_b.dec_we      = drv_we;
    assign if_b.dec_is_load = drv_ld;

    logic [3:0] fwd_sel_a;
    logic [2:0] stg_valid_a, stg_we_a;
    logic [5:0] fwd_sel_b;
    logic [4:0] stg_valid_b, stg_we_b;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_a, kill_cnt_a, stall_cnt_b, kill_cnt_b;
`endif

    hazard_scoreboard u_dut_a (
        .clk       (clk),
        .reset     (reset),
        .freeze    (freeze),
        .kill      (kill),
        .dec       (if_a),
        .fwd_sel   (fwd_sel_a),
        .stg_valid (stg_valid_a),
        .stg_we    (stg_we_a)
`ifdef HAZARD_PERF_EN
        ,
        .perf_stall_cnt (stall_cnt_a),
        .perf_kill_cnt  (kill_cnt_a)
`endif
    );

    hazard_scoreboard #(.STAGES(5), .NUM_SRC(2), .REG_AW(5), .LOAD_STAGE(4)) u_dut_b (
        .clk       (clk),
        .reset     (reset),
        .freeze    (freeze),
        .kill      (kill),
        .dec       (if_b),
        .fwd_sel   (fwd_sel_b),
        .stg_valid (stg_valid_b),
        .stg_we    (stg_we_b)
`ifdef HAZARD_PERF_EN
        ,
        .perf_stall_cnt (stall_cnt_b),
        .perf_kill_cnt  (kill_cnt_b)
`endif
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each slot is an in-flight instruction; a producer's result can be
    // forwarded once it has reached its ready stage (1 for ALU, load stage for loads).
    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       we;
        bit       ld;
    } ent_t;

    ent_t        pipe_m  [2][9];
    int          fwd_m   [2][2];
    int unsigned stall_m [2];
    int unsigned kill_m  [2];
    int          stg_n   [2] = '{3, 5};
    int          ld_n    [2] = '{3, 4};
    int          sw_n    [2] = '{2, 3};

    task automatic m_reset();
        for (int w = 0; w < 2; w++) begin
            for (int s = 0; s < 9; s++) pipe_m[w][s] = '{v: 1'b0, rd: 5'd0, we: 1'b0, ld: 1'b0};
            fwd_m[w][0] = 0;
            fwd_m[w][1] = 0;
            stall_m[w]  = 0;
            kill_m[w]   = 0;
        end
    endtask

    function automatic bit m_writes(int w, int s, bit [4:0] rs);
        return pipe_m[w][s].v && pipe_m[w][s].we && (pipe_m[w][s].rd != 0) && (pipe_m[w][s].rd == rs);
    endfunction

    // Producers in the last stage are visible through the register file.
    function automatic bit m_hazard(int w, bit dv, bit [4:0] rs0, bit [4:0] rs1);
        bit h = 1'b0;
        for (int s = 1; s < stg_n[w]; s++) begin
            int ready_stage = pipe_m[w][s].ld ? ld_n[w] : 1;
            if ((m_writes(w, s, rs0) || m_writes(w, s, rs1)) && (ready_stage - s > 1)) h = 1'b1;
        end
        return dv && h;
    endfunction

    function automatic int m_fwd(int w, bit [4:0] rs);
        for (int s = 1; s < stg_n[w]; s++) begin
            if (m_writes(w, s, rs)) return s + 1;
        end
        return 0;
    endfunction

    task automatic m_clock(int w, bit dv, bit [4:0] rs0, bit [4:0] rs1, bit [4:0] rd,
                           bit we, bit ld, bit kl, bit fz);
        bit hz, take;
        int f0, f1;
        if (fz) return;
        hz   = m_hazard(w, dv, rs0, rs1);
        take = dv && !kl && !hz;
        f0   = take ? m_fwd(w, rs0) : 0;
        f1   = take ? m_fwd(w, rs1) : 0;
        if (hz && !kl) stall_m[w]++;
        if (kl) kill_m[w]++;
        for (int s = stg_n[w]; s >= 2; s--) pipe_m[w][s] = pipe_m[w][s-1];
        pipe_m[w][1] = '{v: take, rd: take ? rd : 5'd0, we: take && we, ld: take && ld};
        fwd_m[w][0] = f0;
        fwd_m[w][1] = f1;
    endtask

    task automatic check_outputs(int w);
        logic [31:0] v_exp, we_exp, f_exp;
        v_exp  = '0;
        we_exp = '0;
        for (int s = 1; s <= stg_n[w]; s++) begin
            v_exp[s-1]  = pipe_m[w][s].v;
            we_exp[s-1] = pipe_m[w][s].v && pipe_m[w][s].we && (pipe_m[w][s].rd != 0);
        end
        f_exp = 32'(fwd_m[w][0]) | (32'(fwd_m[w][1]) << sw_n[w]);
        if (w == 0) begin
            check("A.stg_valid", 32'(stg_valid_a), v_exp);
            check("A.stg_we", 32'(stg_we_a), we_exp);
            check("A.fwd_sel", 32'(fwd_sel_a), f_exp);
`ifdef HAZARD_PERF_EN
            check("A.perf_stall", stall_cnt_a, stall_m[0]);
            check("A.perf_kill", kill_cnt_a, kill_m[0]);
`endif
        end else begin
            check("B.stg_valid", 32'(stg_valid_b), v_exp);
            check("B.stg_we", 32'(stg_we_b), we_exp);
            check("B.fwd_sel", 32'(fwd_sel_b), f_exp);
`ifdef HAZARD_PERF_EN
            check("B.perf_stall", stall_cnt_b, stall_m[1]);
            check("B.perf_kill", kill_cnt_b, kill_m[1]);
`endif
        end
    endtask

    // ---------------- driver tasks ----------------
    bit last_rdy;

    task automatic cycle(input bit dv, input bit [4:0] rs0, input bit [4:0] rs1, input bit [4:0] rd,
                         input bit we, input bit ld, input bit kl, input bit fz,
                         output bit consumed, output bit rdy_obs);
        bit rdy_exp [2];
        @(negedge clk);
        drv_dv = dv;
        drv_rs = {rs1, rs0};
        drv_rd = rd;
        drv_we = we;
        drv_ld = ld;
        kill   = kl;
        freeze = fz;
        #1;
        for (int w = 0; w < 2; w++) begin
            rdy_exp[w] = !fz && !(m_hazard(w, dv && (phase == w), rs0, rs1) && !kl);
        end
        check("A.dec_ready", 32'(if_a.dec_ready), 32'(rdy_exp[0]));
        check("B.dec_ready", 32'(if_b.dec_ready), 32'(rdy_exp[1]));
        rdy_obs  = (phase == 0) ? if_a.dec_ready : if_b.dec_ready;
        consumed = dv && rdy_exp[phase];
        @(posedge clk);
        for (int w = 0; w < 2; w++) m_clock(w, dv && (phase == w), rs0, rs1, rd, we, ld, kl, fz);
        #1;
        check_outputs(0);
        check_outputs(1);
    endtask

    task automatic op(input bit dv, input bit [4:0] rs0, input bit [4:0] rs1, input bit [4:0] rd,
                      input bit we, input bit ld, input bit kl, input bit fz);
        bit c;
        cycle(dv, rs0, rs1, rd, we, ld, kl, fz, c, last_rdy);
    endtask

    task automatic drain();
        repeat (5) op(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_random(input int n);
        bit       have = 1'b0;
        bit       dv = 1'b0, we = 1'b0, ld = 1'b0, kl, fz, cons, ro;
        bit [4:0] r0 = '0, r1 = '0, rdv = '0;
        for (int c = 0; c < n; c++) begin
            if (!have) begin
                dv   = $urandom_range(0, 9) < 8;
                r0   = 5'($urandom_range(0, 7));
                r1   = 5'($urandom_range(0, 7));
                rdv  = 5'($urandom_range(0, 7));
                we   = $urandom_range(0, 9) < 8;
                ld   = $urandom_range(0, 9) < 3;
                have = dv;
            end
            kl = $urandom_range(0, 9) == 0;
            fz = $urandom_range(0, 9) == 0;
            cycle(dv, r0, r1, rdv, we, ld, kl, fz, cons, ro);
            if (cons || !dv) have = 1'b0;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset  = 1'b0;
        freeze = 1'b0;
        kill   = 1'b0;
        drv_dv = 1'b0;
        drv_rs = '0;
        drv_rd = '0;
        drv_we = 1'b0;
        drv_ld = 1'b0;
        phase  = 0;
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset.A.dec_ready", 32'(if_a.dec_ready), 32'd1);
        check("reset.B.dec_ready", 32'(if_b.dec_ready), 32'd1);
        check_outputs(0);
        check_outputs(1);
        reset = 1'b1;

        // ALU chain: add x5, then two readers of x5
        op(1, 5'd0, 5'd0, 5'd5, 1, 0, 0, 0);
        op(1, 5'd5, 5'd0, 5'd6, 1, 0, 0, 0);
        check("alu.ready", 32'(last_rdy), 32'd1);
        check("alu.fwd_s2", 32'(fwd_sel_a[1:0]), 32'd2);
        op(1, 5'd5, 5'd0, 5'd8, 1, 0, 0, 0);
        check("alu.fwd_s3", 32'(fwd_sel_a[1:0]), 32'd3);
        drain();

        // Load-use: lw x7 then reader on rs2
        op(1, 5'd0, 5'd0, 5'd7, 1, 1, 0, 0);
        op(1, 5'd0, 5'd7, 5'd10, 1, 0, 0, 0);
        check("lu.stall", 32'(last_rdy), 32'd0);
        check("lu.bubble", 32'(stg_valid_a[0]), 32'd0);
        op(1, 5'd0, 5'd7, 5'd10, 1, 0, 0, 0);
        check("lu.accept", 32'(last_rdy), 32'd1);
        check("lu.fwd", 32'(fwd_sel_a[3:2]), 32'd3);
        drain();

        // Load-use with kill in the same cycle
        op(1, 5'd0, 5'd0, 5'd7, 1, 1, 0, 0);
        op(1, 5'd0, 5'd7, 5'd10, 1, 0, 1, 0);
        check("lukill.ready", 32'(last_rdy), 32'd1);
        check("lukill.valid", 32'(stg_valid_a), 32'b010);
`ifdef HAZARD_PERF_EN
        check("lukill.kill_cnt", kill_cnt_a, 32'd1);
        check("lukill.stall_cnt", stall_cnt_a, 32'd1);
`endif
        drain();

        // Freeze for 5 cycles during a load-use stall
        op(1, 5'd0, 5'd0, 5'd7, 1, 1, 0, 0);
        for (int k = 0; k < 5; k++) begin
            op(1, 5'd0, 5'd7, 5'd10, 1, 0, k == 2, 1);
            check("frz.ready", 32'(last_rdy), 32'd0);
            check("frz.valid", 32'(stg_valid_a), 32'b001);
            check("frz.fwd", 32'(fwd_sel_a), 32'd0);
        end
        op(1, 5'd0, 5'd7, 5'd10, 1, 0, 0, 0);
        check("frz.stall", 32'(last_rdy), 32'd0);
        check("frz.bubble", 32'(stg_valid_a), 32'b010);
        op(1, 5'd0, 5'd7, 5'd10, 1, 0, 0, 0);
        check("frz.accept", 32'(last_rdy), 32'd1);
        check("frz.fwd_after", 32'(fwd_sel_a[3:2]), 32'd3);
        check("frz.valid_after", 32'(stg_valid_a), 32'b101);
        drain();

        // x0 and we=0 producers never forward or stall
        op(1, 5'd0, 5'd0, 5'd9, 0, 1, 0, 0);
        op(1, 5'd9, 5'd9, 5'd11, 1, 0, 0, 0);
        check("we0.ready", 32'(last_rdy), 32'd1);
        check("we0.fwd", 32'(fwd_sel_a), 32'd0);
        op(1, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0);
        check("x0.stg_we", 32'(stg_we_a[0]), 32'd0);
        check("x0.stg_valid", 32'(stg_valid_a[0]), 32'd1);
        op(1, 5'd0, 5'd0, 5'd12, 1, 0, 0, 0);
        check("x0.ready", 32'(last_rdy), 32'd1);
        check("x0.fwd", 32'(fwd_sel_a), 32'd0);
        drain();

        // Deep pipeline: STAGES=5, LOAD_STAGE=4
        phase = 1;
        op(1, 5'd0, 5'd0, 5'd7, 1, 1, 0, 0);
        op(1, 5'd7, 5'd0, 5'd13, 1, 0, 0, 0);
        check("deep.stall1", 32'(last_rdy), 32'd0);
        op(1, 5'd7, 5'd0, 5'd13, 1, 0, 0, 0);
        check("deep.stall2", 32'(last_rdy), 32'd0);
        op(1, 5'd7, 5'd0, 5'd13, 1, 0, 0, 0);
        check("deep.accept", 32'(last_rdy), 32'd1);
        check("deep.fwd", 32'(fwd_sel_b[2:0]), 32'd4);
        drain();

        run_random(300);

        // Asynchronous reset in the middle of a cycle
        @(negedge clk);
        drv_dv = 1'b0;
        kill   = 1'b0;
        freeze = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        m_reset();
        check("midrst.A.valid", 32'(stg_valid_a), 32'd0);
        check("midrst.B.valid", 32'(stg_valid_b), 32'd0);
        check_outputs(0);
        check_outputs(1);
        @(negedge clk);
        reset = 1'b1;

        phase = 0;
        run_random(300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
